// File: rtl/k_means_iter_sequencer.sv
// Iteration sequencer for the k-means core: scan, drain, divide, convergence check, write-back.
// Optional iteration limit enabled by defining KMEANS_ITER_LIMIT_EN.
module k_means_iter_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int CENT_NUM   = 8,
    parameter int LOG2_CENT  = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int ITER_WIDTH = 8,
    parameter int REG_BASE   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_go,
    input  logic [ADDR_WIDTH-1:0] i_first_addr,
    input  logic [ADDR_WIDTH-1:0] i_last_addr,
    input  logic [ITER_WIDTH-1:0] i_max_iter,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_csb_n,
    output logic                  o_ram_oeb_n,
    output logic                  o_ram_in_reg_en,
    output logic                  o_acc_en,
    output logic                  o_acc_clr_n,
    output logic                  o_first_iter,
    output logic                  o_div_start,
    input  logic                  i_div_done,
    input  logic                  i_div_by_zero,
    output logic [LOG2_CENT-1:0]  o_cent_idx,
    output logic                  o_cnvg_reg_en,
    output logic                  o_cnvg_clr_n,
    input  logic                  i_cnvg_valid,
    input  logic                  i_has_converged,
    output logic                  o_reg_wr,
    output logic [LOG2_CENT:0]    o_reg_num,
    output logic                  o_busy,
    output logic                  o_done_irq,
    output logic [ITER_WIDTH-1:0] o_iter_count,
    output logic                  o_error
);

    localparam int DW = $clog2(PIPE_DEPTH + 1);
    localparam logic [DW-1:0]         DRAIN_LAST = DW'(PIPE_DEPTH - 1);
    localparam logic [LOG2_CENT-1:0]  CENT_LAST  = LOG2_CENT'(CENT_NUM - 1);
    localparam logic [LOG2_CENT-1:0]  CENT_ONE   = LOG2_CENT'(1);
    localparam logic [LOG2_CENT:0]    REG_BASE_W = (LOG2_CENT + 1)'(REG_BASE);
    localparam logic [LOG2_CENT:0]    REG_ONE    = (LOG2_CENT + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ITER_WIDTH-1:0] ITER_ONE   = ITER_WIDTH'(1);
    localparam logic [ITER_WIDTH-1:0] ITER_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_DIVIDE, S_CHECK, S_WB, S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_first;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_sel_n;
    logic [PIPE_DEPTH:1]   r_vld_pipe;
    logic [DW-1:0]         r_drain_cnt;
    logic                  r_acc_clr_n;
    logic                  r_cnvg_clr_n;
    logic                  r_first_iter;
    logic                  r_div_start;
    logic                  r_div_wait;
    logic [LOG2_CENT-1:0]  r_cent_idx;
    logic                  r_cnvg_reg_en;
    logic                  r_reg_wr;
    logic [LOG2_CENT:0]    r_reg_num;
    logic                  r_done_irq;
    logic [ITER_WIDTH-1:0] r_iter_count;
    logic                  r_error;

    logic [ITER_WIDTH-1:0] w_iter_next;
    logic                  w_limit_hit;

    assign w_iter_next = (r_iter_count == ITER_MAX) ? r_iter_count : r_iter_count + ITER_ONE;

`ifdef KMEANS_ITER_LIMIT_EN
    logic [ITER_WIDTH-1:0] w_eff_max;
    assign w_eff_max   = (i_max_iter == '0) ? ITER_ONE : i_max_iter;
    assign w_limit_hit = (w_iter_next >= w_eff_max);
`else
    logic w_unused_max_iter;
    assign w_unused_max_iter = ^i_max_iter;
    assign w_limit_hit       = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_first       <= '0;
            r_last        <= '0;
            r_ram_addr    <= '0;
            r_ram_sel_n   <= 1'b1;
            r_vld_pipe    <= '0;
            r_drain_cnt   <= '0;
            r_acc_clr_n   <= 1'b1;
            r_cnvg_clr_n  <= 1'b1;
            r_first_iter  <= 1'b0;
            r_div_start   <= 1'b0;
            r_div_wait    <= 1'b0;
            r_cent_idx    <= '0;
            r_cnvg_reg_en <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_num     <= '0;
            r_done_irq    <= 1'b0;
            r_iter_count  <= '0;
            r_error       <= 1'b0;
        end else begin
            r_acc_clr_n   <= 1'b1;
            r_cnvg_clr_n  <= 1'b1;
            r_div_start   <= 1'b0;
            r_cnvg_reg_en <= 1'b0;
            r_done_irq    <= 1'b0;

            // acc_en trails each RAM read by the classification latency
            r_vld_pipe[1] <= !r_ram_sel_n;
            for (int k = 2; k <= PIPE_DEPTH; k++)
                r_vld_pipe[k] <= r_vld_pipe[k-1];

            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        if (i_first_addr > i_last_addr) begin
                            r_error    <= 1'b1;
                            r_done_irq <= 1'b1;
                        end else begin
                            r_first      <= i_first_addr;
                            r_last       <= i_last_addr;
                            r_error      <= 1'b0;
                            r_iter_count <= '0;
                            r_first_iter <= 1'b1;
                            r_acc_clr_n  <= 1'b0;
                            r_cnvg_clr_n <= 1'b0;
                            r_ram_addr   <= i_first_addr;
                            r_ram_sel_n  <= 1'b0;
                            r_state      <= S_SCAN;
                        end
                    end
                end

                // stop on equality so last_addr at the top of the range never wraps
                S_SCAN: begin
                    if (r_ram_addr == r_last) begin
                        r_ram_sel_n <= 1'b1;
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_ram_addr <= r_ram_addr + ADDR_ONE;
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_cent_idx  <= '0;
                        r_div_start <= 1'b1;
                        r_div_wait  <= 1'b1;
                        r_state     <= S_DIVIDE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end

                // after each result, one cycle with cent_idx still pointing at that centroid
                S_DIVIDE: begin
                    if (r_div_wait) begin
                        if (i_div_done) begin
                            r_div_wait    <= 1'b0;
                            r_cnvg_reg_en <= !i_div_by_zero;
                        end
                    end else if (r_cent_idx == CENT_LAST) begin
                        r_cent_idx <= '0;
                        r_state    <= S_CHECK;
                    end else begin
                        r_cent_idx  <= r_cent_idx + CENT_ONE;
                        r_div_start <= 1'b1;
                        r_div_wait  <= 1'b1;
                    end
                end

                S_CHECK: begin
                    if (i_cnvg_valid) begin
                        r_iter_count <= w_iter_next;
                        r_first_iter <= 1'b0;
                        if (i_has_converged || w_limit_hit) begin
                            if (!i_has_converged)
                                r_error <= 1'b1;
                            r_cent_idx <= '0;
                            r_reg_wr   <= 1'b1;
                            r_reg_num  <= REG_BASE_W;
                            r_state    <= S_WB;
                        end else begin
                            r_acc_clr_n  <= 1'b0;
                            r_cnvg_clr_n <= 1'b0;
                            r_ram_addr   <= r_first;
                            r_ram_sel_n  <= 1'b0;
                            r_state      <= S_SCAN;
                        end
                    end
                end

                S_WB: begin
                    if (r_cent_idx == CENT_LAST) begin
                        r_reg_wr   <= 1'b0;
                        r_cent_idx <= '0;
                        r_done_irq <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cent_idx <= r_cent_idx + CENT_ONE;
                        r_reg_num  <= REG_BASE_W + {1'b0, r_cent_idx} + REG_ONE;
                    end
                end

                S_DONE: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ram_addr      = r_ram_addr;
    assign o_ram_csb_n     = r_ram_sel_n;
    assign o_ram_oeb_n     = r_ram_sel_n;
    assign o_ram_in_reg_en = !r_ram_sel_n;
    assign o_acc_en        = r_vld_pipe[PIPE_DEPTH];
    assign o_acc_clr_n     = r_acc_clr_n;
    assign o_first_iter    = r_first_iter;
    assign o_div_start     = r_div_start;
    assign o_cent_idx      = r_cent_idx;
    assign o_cnvg_reg_en   = r_cnvg_reg_en;
    assign o_cnvg_clr_n    = r_cnvg_clr_n;
    assign o_reg_wr        = r_reg_wr;
    assign o_reg_num       = r_reg_num;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done_irq      = r_done_irq;
    assign o_iter_count    = r_iter_count;
    assign o_error         = r_error;

endmodule
